core2axi_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares the single core-side memory port of the AXI bridge between two masters, e.g. instruction fetch and load/store. It drives one req/gnt/rvalid transaction stream into the bridge. It keeps an in-order FIFO of master IDs for outstanding transactions so that each response reaches the master that issued it. Grant and response paths are combinational (zero added latency); only arbitration state and the ID FIFO are registered.

---
 rtl/core2axi_arbiter.sv | 170 +++++++++++++++++
 tb/tb_core2axi_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/core2axi_arbiter.sv
// core2axi_arbiter: two-master round-robin arbiter in front of the single
// core-side port of the AXI bridge. Grant and response paths are purely
// combinational; only the arbitration state and an in-order FIFO of master
// IDs (one entry per granted-but-unanswered transaction) are registered.
//
// Ports:
//   clk_i, rst_ni                     clock, synchronous active-low reset
//   m{0,1}_req_i / _gnt_o / _rvalid_o master handshake
//   m{0,1}_addr_i/_we_i/_be_i/_wdata_i master payload
//   m{0,1}_rdata_o                    read data (copy of data_rdata_i)
//   data_req_o / data_gnt_i           downstream request handshake
//   data_addr_o/_we_o/_be_o/_wdata_o  muxed payload of the selected master
//   data_rvalid_i / data_rdata_i      downstream response
//   err_o                             sticky: response with nothing outstanding
module core2axi_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BE_WIDTH    = 4,
  parameter int unsigned OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  m0_req_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic                  m0_we_i,
  input  logic [BE_WIDTH-1:0]   m0_be_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  input  logic                  m1_req_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [BE_WIDTH-1:0]   m1_be_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [BE_WIDTH-1:0]   data_be_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  input  logic [DATA_WIDTH-1:0] data_rdata_i,
  output logic                  err_o
);

  localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);

  typedef enum logic {ARB, HOLD} state_t;

  state_t                 state_q, state_d;
  logic                   sel_q, sel_d;
  logic                   prio_q, prio_d;
  logic [OUTSTANDING-1:0] id_q;
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       count_q;
  logic                   err_q;

  logic full, winner, cur, cur_req, req, push, pop, head, mux_m1;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ARB;
      sel_q   <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      prio_q  <= prio_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    prio_d  = prio_q;
    unique case (state_q)
      ARB: begin
        if (req) begin
          if (data_gnt_i) begin
            prio_d = ~winner;
          end else begin
            sel_d   = winner;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // A locked master dropping its request is illegal; fall back to ARB
        // so the arbiter cannot stay wedged on a vanished request.
        if (!cur_req) begin
          state_d = ARB;
        end else if (req && data_gnt_i) begin
          prio_d  = ~sel_q;
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    full    = (count_q == CNT_W'(OUTSTANDING));
    winner  = (m0_req_i && m1_req_i) ? prio_q : m1_req_i;
    cur     = (state_q == HOLD) ? sel_q : winner;
    cur_req = cur ? m1_req_i : m0_req_i;
    req     = rst_ni && cur_req && !full;
    push    = req && data_gnt_i;
    pop     = rst_ni && data_rvalid_i && (count_q != '0);
    head    = id_q[rd_ptr_q];
    // Idle payload defaults to master 0.
    mux_m1  = req && cur;

    data_req_o   = req;
    data_addr_o  = mux_m1 ? m1_addr_i  : m0_addr_i;
    data_we_o    = mux_m1 ? m1_we_i    : m0_we_i;
    data_be_o    = mux_m1 ? m1_be_i    : m0_be_i;
    data_wdata_o = mux_m1 ? m1_wdata_i : m0_wdata_i;

    m0_gnt_o    = push && !cur;
    m1_gnt_o    = push && cur;
    m0_rvalid_o = pop && !head;
    m1_rvalid_o = pop && head;
    m0_rdata_o  = data_rdata_i;
    m1_rdata_o  = data_rdata_i;
    err_o       = err_q;
  end

  // ID FIFO storage (contents are don't-care while empty, so no reset)
  always_ff @(posedge clk_i) begin
    if (push) begin
      id_q[wr_ptr_q] <= cur;
    end
  end

  // ID FIFO pointers, occupancy and sticky error
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (data_rvalid_i && (count_q == '0)) err_q <= 1'b1;
    end
  end

  // A master locked in HOLD must keep requesting until granted.
  always_ff @(posedge clk_i) begin
    if (rst_ni && (state_q == HOLD)) begin
      assert (cur_req);
    end
  end

endmodule

// File: tb/tb_core2axi_arbiter.sv
// Self-checking bench for core2axi_arbiter: random masters and a random
// downstream memory, compared against a transaction-level model of the
// arbitration rules, with a scoreboard that routes responses by issue order.
module tb_core2axi_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = 4;
  localparam int OUT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          mreq   [2];
  logic [AW-1:0] maddr  [2];
  logic          mwe    [2];
  logic [BW-1:0] mbe    [2];
  logic [DW-1:0] mwdata [2];

  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          data_req, dgnt, drv_rv, err;
  logic [AW-1:0] data_addr;
  logic          data_we;
  logic [BW-1:0] data_be;
  logic [DW-1:0] data_wdata, drv_rdata;

  core2axi_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BE_WIDTH   (BW),
    .OUTSTANDING(OUT)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .m0_req_i     (mreq[0]),
    .m0_gnt_o     (m0_gnt),
    .m0_rvalid_o  (m0_rvalid),
    .m0_addr_i    (maddr[0]),
    .m0_we_i      (mwe[0]),
    .m0_be_i      (mbe[0]),
    .m0_wdata_i   (mwdata[0]),
    .m0_rdata_o   (m0_rdata),
    .m1_req_i     (mreq[1]),
    .m1_gnt_o     (m1_gnt),
    .m1_rvalid_o  (m1_rvalid),
    .m1_addr_i    (maddr[1]),
    .m1_we_i      (mwe[1]),
    .m1_be_i      (mbe[1]),
    .m1_wdata_i   (mwdata[1]),
    .m1_rdata_o   (m1_rdata),
    .data_req_o   (data_req),
    .data_gnt_i   (dgnt),
    .data_rvalid_i(drv_rv),
    .data_addr_o  (data_addr),
    .data_we_o    (data_we),
    .data_be_o    (data_be),
    .data_wdata_o (data_wdata),
    .data_rdata_i (drv_rdata),
    .err_o        (err)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  int owner_q[$];   // downstream view: accepted transactions, oldest first
  int exp_q[$];     // scoreboard: expected owner of each future response
  int prefer = 0;   // master that wins a tie
  bit lock_v = 0;   // a request was presented but not yet accepted
  int lock_id = 0;
  bit err_m = 0;
  int granted = -1; // master whose request was accepted at the last edge

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit in_rst, input bit do_chk, input int err_pct);
    bit cap, preq, exp_req, had_out, exp_rv;
    int pres, idx;
    @(posedge clk);
    #1;
    rst_n = !in_rst;
    if (granted >= 0) mreq[granted] = 1'b0;
    granted = -1;
    for (int i = 0; i < 2; i++) begin
      if (!mreq[i] && $urandom_range(99) < 60) begin
        mreq[i]   = 1'b1;
        maddr[i]  = $urandom;
        mwe[i]    = 1'($urandom_range(1));
        mbe[i]    = BW'($urandom);
        mwdata[i] = $urandom;
      end
    end
    if (in_rst) begin
      dgnt   = 1'b1;
      drv_rv = 1'b1;
    end else begin
      dgnt = 1'($urandom_range(1));
      if (owner_q.size() > 0) drv_rv = 1'($urandom_range(1));
      else drv_rv = ($urandom_range(99) < err_pct);
    end
    drv_rdata = $urandom;
    @(negedge clk);

    cap = (owner_q.size() < OUT);
    if (lock_v) begin
      pres = lock_id;
      preq = mreq[lock_id];
    end else if (mreq[0] && mreq[1]) begin
      pres = prefer;
      preq = 1'b1;
    end else if (mreq[1]) begin
      pres = 1;
      preq = 1'b1;
    end else begin
      pres = 0;
      preq = mreq[0];
    end
    exp_req = preq && cap && !in_rst;
    idx     = exp_req ? pres : 0;
    had_out = (owner_q.size() > 0);
    exp_rv  = drv_rv && had_out && !in_rst;

    if (do_chk) begin
      check("data_req", data_req, exp_req);
      check("data_addr", data_addr, maddr[idx]);
      check("data_we", data_we, mwe[idx]);
      check("data_be", data_be, mbe[idx]);
      check("data_wdata", data_wdata, mwdata[idx]);
      check("m0_gnt", m0_gnt, exp_req && dgnt && pres == 0);
      check("m1_gnt", m1_gnt, exp_req && dgnt && pres == 1);
      check("rvalid_any", m0_rvalid | m1_rvalid, exp_rv);
      check("err", err, err_m);
    end

    if (in_rst) begin
      owner_q.delete();
      exp_q.delete();
      lock_v = 1'b0;
      prefer = 0;
      err_m  = 1'b0;
    end else begin
      if (exp_req && dgnt) begin
        owner_q.push_back(pres);
        exp_q.push_back(pres);
        granted = pres;
        prefer  = 1 - pres;
        lock_v  = 1'b0;
      end else if (exp_req) begin
        lock_v  = 1'b1;
        lock_id = pres;
      end
      if (drv_rv) begin
        if (had_out) void'(owner_q.pop_front());
        else err_m = 1'b1;
      end
    end
  endtask

  // Response monitor: every master rvalid must match the oldest issued owner.
  initial begin
    int o;
    forever begin
      @(negedge clk);
      if (m0_rvalid || m1_rvalid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rv_unexpected actual=%b%b required=00 at %0t", m1_rvalid, m0_rvalid, $time);
        end else begin
          o = exp_q.pop_front();
          check("rv_owner", {m1_rvalid, m0_rvalid}, (o == 1) ? 2'b10 : 2'b01);
          check("rdata", (o == 1) ? m1_rdata : m0_rdata, drv_rdata);
        end
      end
    end
  end

  initial begin
    bit found;
    for (int i = 0; i < 2; i++) begin
      mreq[i] = 1'b0; maddr[i] = '0; mwe[i] = 1'b0; mbe[i] = '0; mwdata[i] = '0;
    end
    dgnt = 1'b0; drv_rv = 1'b0; drv_rdata = '0;

    step(1, 0, 0);
    step(1, 1, 0);
    repeat (1500) step(0, 1, 0);

    // Drive into a stalled (locked) request with a transaction outstanding,
    // then reset on top of it.
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      step(0, 1, 0);
      if (lock_v && owner_q.size() > 0) found = 1'b1;
    end
    step(1, 1, 0);
    step(1, 1, 0);

    // Random traffic including responses with nothing outstanding.
    repeat (1500) step(0, 1, 5);
    step(1, 1, 0);
    repeat (20) step(0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
